// File: rtl/udma_cfg_apb_bridge.sv
// APB slave to uDMA cfg-bus initiator.
// The APB address is split into a peripheral index (paddr[APB_AWIDTH-1:7]) and a
// 5-bit register address (paddr[6:2]). One registered cfg request is issued to the
// selected peripheral, and the captured read data (or an error) is returned on APB.
// An index at or above N_PERIPHS is answered with pslverr and no cfg request.
// Optional feature: define UDMA_CFG_TIMEOUT_EN to abort a request that receives no
// cfg_ready_i within TIMEOUT_CYCLES cycles. Without it, REQ waits indefinitely.
module udma_cfg_apb_bridge #(
   parameter int N_PERIPHS      = 4,
   parameter int APB_AWIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic [APB_AWIDTH-1:0]   apb_paddr_i,
   input  logic [31:0]             apb_pwdata_i,
   input  logic                    apb_pwrite_i,
   input  logic                    apb_psel_i,
   input  logic                    apb_penable_i,
   output logic [31:0]             apb_prdata_o,
   output logic                    apb_pready_o,
   output logic                    apb_pslverr_o,
   output logic [N_PERIPHS-1:0]    cfg_valid_o,
   output logic                    cfg_rwn_o,
   output logic [4:0]              cfg_addr_o,
   output logic [31:0]             cfg_data_o,
   input  logic [32*N_PERIPHS-1:0] cfg_data_i,
   input  logic [N_PERIPHS-1:0]    cfg_ready_i
);

   localparam int IDX_W = (N_PERIPHS > 1) ? $clog2(N_PERIPHS) : 1;
   // The whole upper address field is decoded so that out-of-range indices are caught.
   localparam int HI_W = APB_AWIDTH - 7;
   localparam logic [HI_W:0] N_LIM = (HI_W + 1)'(N_PERIPHS);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [N_PERIPHS-1:0]   cfg_valid_q, cfg_valid_d;
   logic                   cfg_rwn_q, cfg_rwn_d;
   logic [4:0]             cfg_addr_q, cfg_addr_d;
   logic [31:0]            cfg_data_q, cfg_data_d;
   logic [31:0]            prdata_q, prdata_d;
   logic                   pready_q, pready_d;
   logic                   pslverr_q, pslverr_d;

   logic [HI_W-1:0]        hi_idx;
   logic [IDX_W-1:0]       idx_new;
   logic                   idx_ok;
   logic                   ready_sel;
   logic [31:0]            rdata_sel;
   logic                   unused_addr;

   assign hi_idx      = apb_paddr_i[APB_AWIDTH-1:7];
   assign idx_new     = IDX_W'(hi_idx);
   assign idx_ok      = ({1'b0, hi_idx} < N_LIM);
   assign ready_sel   = cfg_ready_i[idx_q];
   assign rdata_sel   = cfg_data_i[32*idx_q +: 32];
   // Byte-lane bits carry no information for word-wide cfg registers.
   assign unused_addr = ^apb_paddr_i[1:0];

`ifdef UDMA_CFG_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_q, tmo_d;
`else
   localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

   // Next-state and next-output logic for the IDLE/REQ/RESP sequencer.
   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      idx_d       = idx_q;
      cfg_valid_d = cfg_valid_q;
      cfg_rwn_d   = cfg_rwn_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_data_d  = cfg_data_q;
      prdata_d    = prdata_q;
      pready_d    = pready_q;
      pslverr_d   = pslverr_q;
`ifdef UDMA_CFG_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif

      case (state_q)
         IDLE: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            // Only the setup phase starts a transfer, so a held access phase never re-triggers.
            if (apb_psel_i && !apb_penable_i) begin
               idx_d      = idx_new;
               cfg_addr_d = apb_paddr_i[6:2];
               cfg_data_d = apb_pwdata_i;
               cfg_rwn_d  = ~apb_pwrite_i;
               if (idx_ok) begin
                  for (int k = 0; k < N_PERIPHS; k++) begin
                     cfg_valid_d[k] = (idx_new == IDX_W'(k));
                  end
`ifdef UDMA_CFG_TIMEOUT_EN
                  tmo_d = '0;
`endif
                  state_d = REQ;
               end else begin
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
                  prdata_d  = '0;
                  state_d   = RESP;
               end
            end
         end

         REQ: begin
            // Ready is checked before the timeout so a same-cycle ready completes normally.
            if (ready_sel) begin
               cfg_valid_d = '0;
               pready_d    = 1'b1;
               pslverr_d   = 1'b0;
               prdata_d    = cfg_rwn_q ? rdata_sel : 32'h0;
               state_d     = RESP;
            end
`ifdef UDMA_CFG_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               cfg_valid_d = '0;
               pready_d    = 1'b1;
               pslverr_d   = 1'b1;
               prdata_d    = '0;
               state_d     = RESP;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
`endif
         end

         RESP: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            state_d   = IDLE;
         end

         default: begin
            cfg_valid_d = '0;
            pready_d    = 1'b0;
            pslverr_d   = 1'b0;
            prdata_d    = '0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any pending request at once.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cfg_valid_q <= '0;
         cfg_rwn_q   <= 1'b1;
         cfg_addr_q  <= '0;
         cfg_data_q  <= '0;
         prdata_q    <= '0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
`ifdef UDMA_CFG_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
         state_q     <= state_d;
         idx_q       <= idx_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_rwn_q   <= cfg_rwn_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_data_q  <= cfg_data_d;
         prdata_q    <= prdata_d;
         pready_q    <= pready_d;
         pslverr_q   <= pslverr_d;
`ifdef UDMA_CFG_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign apb_prdata_o  = prdata_q;
   assign apb_pready_o  = pready_q;
   assign apb_pslverr_o = pslverr_q;
   assign cfg_valid_o   = cfg_valid_q;
   assign cfg_rwn_o     = cfg_rwn_q;
   assign cfg_addr_o    = cfg_addr_q;
   assign cfg_data_o    = cfg_data_q;

endmodule

// File: doc/udma_cfg_apb_bridge.md
Name: udma_cfg_apb_bridge

Overview:
APB slave to uDMA cfg-bus initiator. It is the requesting end of the cfg_valid/cfg_rwn/cfg_addr/cfg_data/cfg_ready interface that each uDMA peripheral register interface (SPI master, etc.) responds on. It decodes the APB address into a peripheral index and a 5-bit register address, and issues one registered cfg request to the selected peripheral. It then returns the captured read data, or an error, on APB.

Parameters:
N_PERIPHS, 4, number of attached cfg-bus responders (1..32)
APB_AWIDTH, 12, APB address width; must be >= 7 + clog2(N_PERIPHS)
TIMEOUT_CYCLES, 16, cycles to wait for cfg_ready_i before error (used only with UDMA_CFG_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  asynchronous active-low reset
apb_paddr_i  in  APB_AWIDTH  byte address; [6:2]=register, [7+:clog2(N_PERIPHS)]=peripheral index
apb_pwdata_i  in  32  write data
apb_pwrite_i  in  1  1=write, 0=read
apb_psel_i  in  1  APB select
apb_penable_i  in  1  APB enable
apb_prdata_o  out  32  read data, valid while apb_pready_o=1
apb_pready_o  out  1  transfer complete
apb_pslverr_o  out  1  error, valid while apb_pready_o=1
cfg_valid_o  out  N_PERIPHS  one-hot request strobe per peripheral
cfg_rwn_o  out  1  1=read, 0=write (shared)
cfg_addr_o  out  5  register address (shared)
cfg_data_o  out  32  write data (shared)
cfg_data_i  in  32*N_PERIPHS  read data, slice k = peripheral k, combinational in responder
cfg_ready_i  in  N_PERIPHS  per-peripheral ready

Behaviour:
- Reset values:
  - cfg_valid_o=0, cfg_rwn_o=1, cfg_addr_o=0, cfg_data_o=0
  - apb_pready_o=0, apb_pslverr_o=0, apb_prdata_o=0
  - FSM in IDLE
- All outputs are registered. No combinational path from APB inputs to cfg outputs.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Accept only on the setup phase (psel=1, penable=0).
  - On accept, latch idx, register address, pwdata and ~pwrite.
  - idx < N_PERIPHS: next cycle cfg_valid_o[idx]=1, other bits 0 -> REQ.
  - idx >= N_PERIPHS: no cfg_valid; -> RESP with pslverr=1, prdata=0.
- REQ:
  - cfg_valid_o, cfg_addr_o, cfg_rwn_o and cfg_data_o are held stable.
  - Each cycle, sample cfg_ready_i[idx].
  - When it is 1:
    - read: capture cfg_data_i slice idx into prdata.
    - write: set prdata to 0.
    - Clear cfg_valid_o next cycle and go to RESP with pslverr=0.
  - Exactly one cfg_valid_o cycle is seen per accepted ready, so a write pulse register fires once.
- RESP:
  - apb_pready_o=1 for exactly one cycle, with prdata and pslverr.
  - Next cycle pready=0, pslverr=0, prdata=0 -> IDLE.
- Latency with an always-ready responder:
  - setup T0, cfg_valid T1 (ready sampled T1), pready T2.
  - One APB wait state.
- Back-to-back transfers: a new setup phase in the cycle after RESP is accepted normally.
- psel deasserted mid-transfer (protocol violation): the cfg transaction still completes and RESP still pulses once. No hang, no duplicate request.
- Async reset mid-REQ: cfg_valid_o drops immediately, FSM to IDLE, no response issued.

Optional Feature:
UDMA_CFG_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ready.
  - When it reaches TIMEOUT_CYCLES-1 with no ready, cfg_valid_o drops and the FSM goes to RESP with pslverr=1, prdata=0.
  - Ready arriving in the same cycle as the timeout wins, giving a normal completion.
- Undefined: no counter; REQ waits indefinitely for cfg_ready_i.

Test Plan:
- APB write 0x0000_1234 to paddr 0x088 (idx 1, reg 2), ready tied 1 -> one-cycle cfg_valid_o=4'b0010 with addr=2, rwn=0, data=0x1234; pready at T2, pslverr=0.
- APB read paddr 0x104 (idx 2, reg 1), cfg_data_i slice 2=0xCAFE_F00D, ready tied 1 -> prdata=0xCAFE_F00D, pslverr=0, cfg_valid_o=4'b0100 for one cycle.
- Read idx 0 with cfg_ready_i[0] held low 5 cycles -> cfg_valid_o[0] stays 1 for 6 cycles with stable addr; pready one cycle after ready rises.
- paddr 0x200 (idx 4, N_PERIPHS=4) -> no cfg_valid_o bit ever set; pready=1, pslverr=1, prdata=0 at T1.
- With UDMA_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=16, ready never asserted -> cfg_valid_o high 16 cycles then pslverr=1, pready=1. Without the macro -> no pready after 100 cycles.
- Assert rstn_i low while in REQ -> cfg_valid_o=0 asynchronously. A subsequent write to idx 3 completes normally.
